// File: rtl/fpu_pkg.sv
// Shared FPU types: FMA opcodes, arbiter FSM states and the canonical FP32 quiet NaN.
package fpu_pkg;

    typedef enum logic [1:0] {
        FMADD  = 2'd0,
        FMSUB  = 2'd1,
        FNMSUB = 2'd2,
        FNMADD = 2'd3
    } fma_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } fma_arb_state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_fma_arb_if.sv
// Bundle of requester, response and fpu_fma-facing signals around the shared FMA arbiter.
interface fpu_fma_arb_if
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_operA;
    logic [NUM_REQ*32-1:0] req_operB;
    logic [NUM_REQ*32-1:0] req_operC;
    logic [NUM_REQ*2-1:0]  req_opcode;
    logic [NUM_REQ*3-1:0]  req_frm;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_rd;
    logic                  resp_nx;
    logic                  resp_err;

    logic                  fma_start;
    logic [31:0]           fma_operA;
    logic [31:0]           fma_operB;
    logic [31:0]           fma_operC;
    fma_op_t               fma_opcode;
    logic [2:0]            fma_frm;
    logic [31:0]           fma_rd;
    logic                  fma_nx;
    logic                  fma_done;

    // Environment side: requesters, response consumer and the fpu_fma instance.
    modport master (
        output req_valid, req_operA, req_operB, req_operC, req_opcode, req_frm,
        input  req_ready,
        input  resp_valid, resp_id, resp_rd, resp_nx, resp_err,
        output resp_ready,
        input  fma_start, fma_operA, fma_operB, fma_operC, fma_opcode, fma_frm,
        output fma_rd, fma_nx, fma_done
    );

    modport slave (
        input  req_valid, req_operA, req_operB, req_operC, req_opcode, req_frm,
        output req_ready,
        output resp_valid, resp_id, resp_rd, resp_nx, resp_err,
        input  resp_ready,
        output fma_start, fma_operA, fma_operB, fma_operC, fma_opcode, fma_frm,
        input  fma_rd, fma_nx, fma_done
    );

endinterface

// File: rtl/fpu_fma_arb_rr_arbiter.sv
// Round-robin one-hot arbiter: the search starts just after ptr and wraps around.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;
    int   idx;

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_fma_arb.sv
// Shares one fpu_fma among NUM_REQ requesters: round-robin grant, operand hold,
// start/done sequencing with timeout, and a tagged response port with backpressure.
module fpu_fma_arb
    import fpu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    fpu_fma_arb_if.slave bus
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

    fma_arb_state_t   state, state_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]  rr_ptr, grant_id, hold_id;
    logic [TMO_W-1:0] tmo_cnt;
    logic             handshake, tmo_hit;

    logic [31:0]      sel_a, sel_b, sel_c;
    logic [1:0]       sel_op;
    logic [2:0]       sel_frm;

    logic [31:0]      hold_a, hold_b, hold_c, rd_q;
    fma_op_t          hold_op;
    logic [2:0]       hold_frm;
    logic             nx_q, err_q;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_c    = '0;
        sel_op   = '0;
        sel_frm  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                grant_id = ID_W'(i);
                sel_a    = bus.req_operA[32*i +: 32];
                sel_b    = bus.req_operB[32*i +: 32];
                sel_c    = bus.req_operC[32*i +: 32];
                sel_op   = bus.req_opcode[2*i +: 2];
                sel_frm  = bus.req_frm[3*i +: 3];
            end
        end
    end

    assign handshake = (state == IDLE) && (|gnt);
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (handshake) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (bus.fma_done || tmo_hit) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are also masked by reset so nothing handshakes while held in reset.
    always_comb begin
        bus.req_ready  = (state == IDLE && rst) ? gnt : '0;
        bus.fma_start  = (state == ISSUE);
        bus.resp_valid = (state == RESP);
    end

    // NOTE: hold and response registers are reset as well, so the fma_* and resp_*
    // outputs read zero after reset instead of stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            hold_id  <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
            hold_c   <= '0;
            hold_op  <= FMADD;
            hold_frm <= '0;
            tmo_cnt  <= '0;
            rd_q     <= '0;
            nx_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr   <= grant_id;
                hold_id  <= grant_id;
                hold_a   <= sel_a;
                hold_b   <= sel_b;
                hold_c   <= sel_c;
                hold_op  <= fma_op_t'(sel_op);
                hold_frm <= sel_frm;
            end
            if (state == ISSUE) tmo_cnt <= '0;
            if (state == BUSY) begin
                if (bus.fma_done) begin
                    rd_q  <= bus.fma_rd;
                    nx_q  <= bus.fma_nx;
                    err_q <= 1'b0;
                end else if (tmo_hit) begin
                    rd_q  <= FP32_QNAN;
                    nx_q  <= 1'b0;
                    err_q <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.fma_operA  = hold_a;
    assign bus.fma_operB  = hold_b;
    assign bus.fma_operC  = hold_c;
    assign bus.fma_opcode = hold_op;
    assign bus.fma_frm    = hold_frm;
    assign bus.resp_id    = hold_id;
    assign bus.resp_rd    = rd_q;
    assign bus.resp_nx    = nx_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_fpu_fma_arb.sv
// Randomized bench for fpu_fma_arb with an FMA stub and a queue-based reference model.
module tb_fpu_fma_arb;
    import fpu_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int ID_W        = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpu_fma_arb_if #(.NUM_REQ(NUM_REQ)) bus();

    fpu_fma_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---- reference arithmetic (truncating FP32 via real) ----
    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        m = m * (2.0 ** e);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [32:0] r2f(input real r_in);
        real r, f;
        int  e, m;
        logic s;
        r = r_in;
        if (r == 0.0) return 33'd0;
        s = (r < 0.0);
        if (s) r = -r;
        e = 0;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        f = (r - 1.0) * 8388608.0;
        m = $rtoi(f);
        return {(f != real'(m)), s, 8'(e + 127), 23'(m)};
    endfunction

    function automatic logic [32:0] fma_ref(input logic [31:0] a, b, c, input logic [1:0] op);
        real p, cc, r;
        p  = f2r(a) * f2r(b);
        cc = f2r(c);
        case (op)
            2'd0:    r = p + cc;
            2'd1:    r = p - cc;
            2'd2:    r = -p + cc;
            default: r = -p - cc;
        endcase
        return r2f(r);
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(124, 130)), 23'($urandom)};
    endfunction

    function automatic int exp_winner(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    // ---- FMA stub ----
    int stub_en    = 1;
    int stub_lat   = 0;
    int stray_cnt  = 0;
    int stray_seen = 0;
    int stub_cnt   = 0;
    bit stub_busy  = 0;

    initial begin
        logic [32:0] r;
        bus.fma_done = 1'b0;
        bus.fma_rd   = '0;
        bus.fma_nx   = 1'b0;
        forever begin
            @(negedge clk);
            bus.fma_done = 1'b0;
            if (!rst) begin
                stub_busy = 0;
            end else if (stray_cnt != stray_seen) begin
                stray_seen   = stray_cnt;
                bus.fma_done = 1'b1;
                bus.fma_rd   = 32'h1234_5678;
                bus.fma_nx   = 1'b1;
            end else if (bus.fma_start && stub_en != 0) begin
                stub_busy = 1;
                stub_cnt  = (stub_lat == 0) ? int'($urandom_range(1, 6)) : stub_lat;
            end else if (stub_busy) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    r = fma_ref(bus.fma_operA, bus.fma_operB, bus.fma_operC, bus.fma_opcode);
                    bus.fma_rd   = r[31:0];
                    bus.fma_nx   = r[32];
                    bus.fma_done = 1'b1;
                    stub_busy    = 0;
                end
            end
        end
    end

    // ---- reference model / scoreboard ----
    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     rd;
        logic            nx;
        logic            err;
    } exp_t;

    exp_t sb_q[$];
    int   grants[$];
    int   last_gnt = NUM_REQ - 1;
    int   n_start  = 0;

    initial begin
        int          w;
        logic [32:0] r;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete();
                last_gnt = NUM_REQ - 1;
            end else begin
                if (bus.fma_start) n_start++;
                if (sb_q.size() == 0) begin
                    w = exp_winner(bus.req_valid, last_gnt);
                    check("grant", bus.req_ready,
                          (w < 0) ? 64'd0 : (64'd1 << w));
                    if (w >= 0 && bus.req_ready[w]) begin
                        grants.push_back(w);
                        last_gnt = w;
                        e.id = ID_W'(w);
                        if (stub_en != 0) begin
                            r = fma_ref(bus.req_operA[32*w +: 32], bus.req_operB[32*w +: 32],
                                        bus.req_operC[32*w +: 32], bus.req_opcode[2*w +: 2]);
                            e.rd = r[31:0]; e.nx = r[32]; e.err = 1'b0;
                        end else begin
                            e.rd = 32'h7FC0_0000; e.nx = 1'b0; e.err = 1'b1;
                        end
                        sb_q.push_back(e);
                    end
                end else begin
                    check("ready_while_busy", bus.req_ready, 0);
                end
                if (bus.resp_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_resp", bus.resp_valid, 0);
                    end else if (bus.resp_ready) begin
                        e = sb_q.pop_front();
                        check("resp_id",  bus.resp_id,  e.id);
                        check("resp_rd",  bus.resp_rd,  e.rd);
                        check("resp_nx",  bus.resp_nx,  e.nx);
                        check("resp_err", bus.resp_err, e.err);
                    end
                end
            end
        end
    end

    // ---- driver helpers ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, b, c,
                           input logic [1:0] op, input logic [2:0] frm);
        bus.req_operA[32*i +: 32] = a;
        bus.req_operB[32*i +: 32] = b;
        bus.req_operC[32*i +: 32] = c;
        bus.req_opcode[2*i +: 2]  = op;
        bus.req_frm[3*i +: 3]     = frm;
    endtask

    task automatic rand_all();
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, rand_fp(), rand_fp(), rand_fp(), 2'($urandom), 3'($urandom));
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.resp_valid && n < 300) begin tick(); n++; end
        if (!bus.resp_valid) check("wait_resp_budget", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || bus.resp_valid) && n < 500) begin tick(); n++; end
        if (n >= 500) check("drain_budget", 0, 1);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---- directed and random stimulus ----
    initial begin
        int          n, g0, s0;
        logic [31:0] sa, sb, sc, srd;
        logic [1:0]  sop;
        logic [2:0]  sfrm;
        logic [ID_W-1:0] sid;
        logic        snx, serr;

        bus.req_valid  = '0;
        bus.req_operA  = '0;
        bus.req_operB  = '0;
        bus.req_operC  = '0;
        bus.req_opcode = '0;
        bus.req_frm    = '0;
        bus.resp_ready = 1'b0;

        // Reset state, with requests pending so a grant would be visible.
        rand_all();
        bus.req_valid = '1;
        tick();
        tick();
        check("rst_req_ready",  bus.req_ready,  0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_fma_start",  bus.fma_start,  0);
        check("rst_fma_operA",  bus.fma_operA,  0);
        check("rst_resp_rd",    bus.resp_rd,    0);
        check("rst_resp_err",   bus.resp_err,   0);
        bus.req_valid = '0;
        rst = 1'b1;
        tick();

        // Single request from requester 0: 1.0*2.0+1.0 = 3.0.
        set_req(0, 32'h3f80_0000, 32'h4000_0000, 32'h3f80_0000, FMADD, 3'd0);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'b0001;
        #1;
        check("t1_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        check("t1_start_latency", bus.fma_start, 1);
        check("t1_operB", bus.fma_operB, 32'h4000_0000);
        wait_resp(n);
        check("t1_resp_id",  bus.resp_id,  0);
        check("t1_resp_rd",  bus.resp_rd,  32'h4040_0000);
        check("t1_resp_nx",  bus.resp_nx,  0);
        check("t1_resp_err", bus.resp_err, 0);
        drain();

        // Rotation with every requester valid after a fresh reset.
        do_reset();
        rand_all();
        g0 = grants.size();
        s0 = n_start;
        bus.req_valid = '1;
        n = 0;
        while (grants.size() < g0 + 5 && n < 300) begin tick(); n++; end
        bus.req_valid = '0;
        if (grants.size() < g0 + 5) check("rot_budget", 0, 1);
        drain();
        for (int k = 0; k < 5; k++)
            if (g0 + k < grants.size()) check("rot_order", grants[g0 + k], k % NUM_REQ);
        check("rot_starts", n_start - s0, 5);

        // Backpressure: response held for 10 cycles.
        bus.resp_ready = 1'b0;
        rand_all();
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        wait_resp(n);
        sid = bus.resp_id; srd = bus.resp_rd; snx = bus.resp_nx; serr = bus.resp_err;
        check("stall_id", sid, 2);
        bus.req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_valid", bus.resp_valid, 1);
            check("stall_rd",    bus.resp_rd,    srd);
            check("stall_meta",  {bus.resp_id, bus.resp_nx, bus.resp_err}, {sid, snx, serr});
            check("stall_ready", bus.req_ready, 0);
            check("stall_start", bus.fma_start, 0);
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        tick();
        check("stall_release", bus.resp_valid, 0);
        drain();

        // Requester lines change while the operation is in flight.
        stub_lat = 8;
        rand_all();
        sa = rand_fp(); sb = rand_fp(); sc = rand_fp(); sop = FNMSUB; sfrm = 3'd3;
        set_req(2, sa, sb, sc, sop, sfrm);
        bus.req_valid = '0;
        tick();
        bus.req_valid = 4'b0100;
        #1;
        check("hold_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        rand_all();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_A", bus.fma_operA, sa);
            check("hold_B", bus.fma_operB, sb);
            check("hold_C", bus.fma_operC, sc);
            check("hold_op_frm", {bus.fma_opcode, bus.fma_frm}, {sop, sfrm});
        end
        drain();
        stub_lat = 0;

        // Timeout: the stub never answers; a late done in IDLE is ignored.
        stub_en = 0;
        bus.req_valid = 4'b0010;
        #1;
        n = 0;
        tick(); n++;
        bus.req_valid = '0;
        while (!bus.resp_valid && n < 200) begin tick(); n++; end
        check("tmo_latency", n, TIMEOUT_CYC + 2);
        check("tmo_err", bus.resp_err, 1);
        check("tmo_rd",  bus.resp_rd,  32'h7FC0_0000);
        check("tmo_nx",  bus.resp_nx,  0);
        check("tmo_id",  bus.resp_id,  1);
        tick();
        stray_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stray_no_resp",  bus.resp_valid, 0);
            check("stray_no_start", bus.fma_start,  0);
        end
        stub_en = 1;
        drain();

        // Asynchronous reset in BUSY drops the operation.
        stub_lat = 20;
        rand_all();
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_resp_valid", bus.resp_valid, 0);
        check("arst_start",      bus.fma_start,  0);
        check("arst_operA",      bus.fma_operA,  0);
        check("arst_resp_rd",    bus.resp_rd,    0);
        check("arst_resp_id",    bus.resp_id,    0);
        bus.req_valid = '1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_first_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        stub_lat = 0;
        drain();

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            rand_all();
            bus.req_valid  = 4'($urandom);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        drain();

        check("sb_empty", sb_q.size(), 0);
        check("start_per_grant", n_start, grants.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
